// File: rtl/esl_sysid_checker.sv
// esl_sysid_checker: Avalon-MM read master that fetches the sysid ID and timestamp
// words and reports whether they match the values this build was generated with.
module esl_sysid_checker #(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0]       EXPECTED_TS    = 32'h6098_447C,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter bit                AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] TS_ADDR  = BASE_ADDR + ADDR_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID_REQ,
    S_ID_WAIT,
    S_TS_REQ,
    S_TS_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                auto_q, auto_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                read_q, read_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                tmo_q, tmo_d;
  logic [31:0]         id_q, id_d;
  logic [31:0]         ts_q, ts_d;
  logic                expired;
  logic                abort;

  // The counter is only reloaded on a new check and between the two reads,
  // so it covers request plus response cycles of one read.
  assign expired = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    ts_d    = ts_q;
    abort   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start || auto_q) begin
          state_d = S_ID_REQ;
          auto_d  = 1'b0;
          cnt_d   = '0;
          read_d  = 1'b1;
          addr_d  = BASE_ADDR;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_ID_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!avm_waitrequest) begin
          state_d = S_ID_WAIT;
          read_d  = 1'b0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_ID_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (avm_readdatavalid) begin
          id_d    = avm_readdata;
          state_d = S_TS_REQ;
          cnt_d   = '0;
          read_d  = 1'b1;
          addr_d  = TS_ADDR;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_TS_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!avm_waitrequest) begin
          state_d = S_TS_WAIT;
          read_d  = 1'b0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_TS_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (avm_readdatavalid) begin
          ts_d    = avm_readdata;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Captured words are deliberately left as they are on a timeout.
    if (abort) begin
      state_d = S_DONE;
      read_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = 1'b0;
      tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      auto_q  <= AUTO_START;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout_err = tmo_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_esl_sysid_checker.sv
// Bench for esl_sysid_checker: one Avalon slave model shared by an auto-start and a
// manual-start instance, with a scoreboard of expected check results.
`timescale 1ns/1ps
module tb_esl_sysid_checker;

  localparam logic [31:0] A_BASE  = 32'h0000_0000;
  localparam logic [31:0] B_BASE  = 32'hFFFF_FFFC;
  localparam logic [31:0] GOOD_TS = 32'h6098_447C;
  localparam logic [31:0] BAD_TS  = 32'h6098_447D;
  localparam logic [31:0] B_ID    = 32'h1234_5678;

  typedef struct {
    logic        p;
    logic        t;
    logic [31:0] id;
    logic [31:0] ts;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic rst_a_n, rst_b_n, start_s, sel;
  logic start_a, start_b;
  logic avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic [31:0] a_addr, b_addr, a_id, b_id, a_ts, b_ts;
  logic a_read, b_read, a_busy, b_busy, a_done, b_done, a_pass, b_pass, a_to, b_to;
  logic [31:0] m_addr, m_id, m_ts, m_base;
  logic m_read, m_busy, m_done, m_pass, m_to, m_rst_n;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  int          stall, lat, inj_req;
  bit          stuck, chk_stable;
  logic [31:0] id_data, ts_data, inj_data;
  int          acc_cnt;

  assign start_a = start_s & ~sel;
  assign start_b = start_s & sel;
  assign m_addr  = sel ? b_addr : a_addr;
  assign m_id    = sel ? b_id   : a_id;
  assign m_ts    = sel ? b_ts   : a_ts;
  assign m_read  = sel ? b_read : a_read;
  assign m_busy  = sel ? b_busy : a_busy;
  assign m_done  = sel ? b_done : a_done;
  assign m_pass  = sel ? b_pass : a_pass;
  assign m_to    = sel ? b_to   : a_to;
  assign m_rst_n = sel ? rst_b_n : rst_a_n;
  assign m_base  = sel ? B_BASE : A_BASE;

  esl_sysid_checker #(.TIMEOUT_CYCLES(16)) dut_a (
    .clock(clock), .reset_n(rst_a_n), .start(start_a),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout_err(a_to),
    .id_value(a_id), .ts_value(a_ts)
  );

  esl_sysid_checker #(.BASE_ADDR(B_BASE), .EXPECTED_ID(B_ID), .TIMEOUT_CYCLES(16),
                      .AUTO_START(1'b0)) dut_b (
    .clock(clock), .reset_n(rst_b_n), .start(start_b),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout_err(b_to),
    .id_value(b_id), .ts_value(b_ts)
  );

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic p, input logic t, input logic [31:0] id,
                          input logic [31:0] ts, input int c);
    exp_t e;
    e.p = p; e.t = t; e.id = id; e.ts = ts; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Start is sampled at edge n; n is also the sampled cycle in which ID_REQ shows.
  task automatic pulse_start(output int n);
    @(negedge clock);
    start_s = 1'b1;
    n = cyc + 1;
    @(negedge clock);
    start_s = 1'b0;
    chk("start_clr_done", m_done, 0);
    chk("start_clr_pass", m_pass, 0);
    chk("start_busy", m_busy, 1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sbq.size() > 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (sbq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_wait: %0d results outstanding after %0d cycles", sbq.size(), k);
      sbq.delete();
    end
  endtask

  // Avalon slave: programmable stall and latency, data chosen by address.
  initial begin
    logic        prev_read, prev_wait;
    logic [31:0] prev_addr, resp_data;
    int          wcnt, timer, inj_seen;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    prev_read = 1'b0; prev_wait = 1'b0; prev_addr = '0; resp_data = '0;
    wcnt = 0; timer = 0; inj_seen = 0; acc_cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      avm_readdatavalid = 1'b0;
      if (!m_busy) acc_cnt = 0;
      if (!m_rst_n) begin
        timer = 0;
        wcnt  = 0;
      end else begin
        if (prev_read && !prev_wait) begin
          timer     = lat;
          wcnt      = 0;
          acc_cnt++;
          resp_data = (prev_addr == m_base + 32'd4) ? ts_data : id_data;
        end
        if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = resp_data;
          end
        end
      end
      if (inj_req != inj_seen) begin
        inj_seen          = inj_req;
        avm_readdatavalid = 1'b1;
        avm_readdata      = inj_data;
      end
      if (m_read) begin
        if (stuck) avm_waitrequest = 1'b1;
        else if (wcnt < stall) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else avm_waitrequest = 1'b0;
      end else begin
        avm_waitrequest = 1'b0;
        wcnt = 0;
      end
      prev_read = m_read;
      prev_wait = avm_waitrequest;
      prev_addr = m_addr;
    end
  end

  // Monitor: address stability under stall, and scoreboard pop on each done rise.
  initial begin
    logic done_prev, s_read, s_wait;
    int   txn;
    exp_t e;
    done_prev = 1'b0; s_read = 1'b0; s_wait = 1'b0; txn = 0;
    forever begin
      @(negedge clock);
      if (chk_stable && s_read && s_wait) begin
        chk("stall_read", m_read, 1);
        chk("stall_addr", m_addr, (acc_cnt == 0) ? m_base : m_base + 32'd4);
      end
      if (m_done && !done_prev) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done rose at cyc %0d, expected none", cyc);
        end else begin
          e = sbq.pop_front();
          txn++;
          $display("txn %0d: done cyc=%0d pass=%0b timeout=%0b id=%h ts=%h",
                   txn, cyc, m_pass, m_to, m_id, m_ts);
          chk("done_cycle", cyc, e.cyc);
          chk("pass", m_pass, e.p);
          chk("timeout_err", m_to, e.t);
          chk("id_value", m_id, e.id);
          chk("ts_value", m_ts, e.ts);
          chk("busy_at_done", m_busy, 0);
        end
      end
      done_prev = m_done;
      s_read    = m_read;
      s_wait    = avm_waitrequest;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rel;
    sel = 1'b0; start_s = 1'b0; stall = 0; lat = 1; stuck = 1'b0; chk_stable = 1'b0;
    id_data = '0; ts_data = GOOD_TS; inj_data = '0; inj_req = 0;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    #2;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_read", m_read, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_pass", m_pass, 0);
    chk("rst_timeout", m_to, 0);

    // Auto-start after release, latency-1 zero-wait slave
    rst_a_n = 1'b1;
    rel = cyc;
    push_exp(1'b1, 1'b0, 32'h0, GOOD_TS, rel + 5);
    @(negedge clock);
    chk("auto_read", m_read, 1);
    chk("auto_addr", m_addr, A_BASE);
    wait_drain();

    // Timestamp mismatch, plus a start pulse while busy that must be ignored
    ts_data = BAD_TS;
    pulse_start(n);
    push_exp(1'b0, 1'b0, 32'h0, BAD_TS, n + 4);
    @(negedge clock);
    start_s = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    wait_drain();
    repeat (4) @(negedge clock);
    chk("no_rerun_busy", m_busy, 0);
    chk("done_held", m_done, 1);

    // Three stall cycles per read and latency 2
    ts_data = GOOD_TS; stall = 3; lat = 2; chk_stable = 1'b1;
    pulse_start(n);
    push_exp(1'b1, 1'b0, 32'h0, GOOD_TS, n + 12);
    wait_drain();
    chk_stable = 1'b0; stall = 0; lat = 1;

    // Waitrequest stuck high: timeout keeps previous captured words
    stuck = 1'b1;
    pulse_start(n);
    push_exp(1'b0, 1'b1, 32'h0, GOOD_TS, n + 16);
    wait_drain();
    @(negedge clock);
    chk("tmo_read_low", m_read, 0);
    stuck = 1'b0;
    inj_data = 32'hDEAD_BEEF;
    inj_req++;
    repeat (3) @(negedge clock);
    chk("stray_done", m_done, 1);
    chk("stray_pass", m_pass, 0);
    chk("stray_timeout", m_to, 1);
    chk("stray_id", m_id, 32'h0);
    chk("stray_ts", m_ts, GOOD_TS);
    chk("stray_read", m_read, 0);

    // Manual-start instance with a wrapping base address
    sel = 1'b1; id_data = B_ID;
    @(negedge clock);
    rst_b_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("noauto_read", m_read, 0);
    end
    pulse_start(n);
    push_exp(1'b1, 1'b0, B_ID, GOOD_TS, n + 4);
    wait_drain();

    // Reset during TS_WAIT, then no read until start
    lat = 2;
    pulse_start(n);
    repeat (3) @(negedge clock);
    chk("ts_req_read", m_read, 1);
    chk("ts_addr_wrap", m_addr, 32'h0);
    @(negedge clock);
    chk("ts_wait_busy", m_busy, 1);
    chk("ts_wait_id", m_id, B_ID);
    rst_b_n = 1'b0;
    #1;
    chk("arst_read", m_read, 0);
    chk("arst_addr", m_addr, 0);
    chk("arst_busy", m_busy, 0);
    chk("arst_done", m_done, 0);
    chk("arst_id", m_id, 0);
    chk("arst_ts", m_ts, 0);
    lat = 1;
    @(negedge clock);
    rst_b_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_rst_noread", m_read, 0);
    end
    pulse_start(n);
    push_exp(1'b1, 1'b0, B_ID, GOOD_TS, n + 4);
    wait_drain();
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
